// File: rtl/fpga_reg_burst_reader.sv
// Purpose: streams a contiguous, wrapping range of register-file words out on a valid/ready port.
// Latency: first beat valid one cycle after command accept; one beat per cycle thereafter.
// Backpressure: m_ready low holds the current beat stable; no new word is fetched until it is taken.
module fpga_reg_burst_reader #(
    parameter int DATA_WIDTH_P    = 8,
    parameter int ADDRESS_WIDTH_P = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [ADDRESS_WIDTH_P-1:0] cmd_start_address,
    input  logic [ADDRESS_WIDTH_P-1:0] cmd_length_m1,
    output logic [ADDRESS_WIDTH_P-1:0] mem_address,
    input  logic [DATA_WIDTH_P-1:0]    mem_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_WIDTH_P-1:0]    m_data,
    output logic                       m_last,
    output logic                       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    localparam logic [ADDRESS_WIDTH_P-1:0] ADDR_ONE = ADDRESS_WIDTH_P'(1);
    localparam logic [ADDRESS_WIDTH_P-1:0] ADDR_ZERO = '0;

    state_t                      state_q, state_d;
    logic [ADDRESS_WIDTH_P-1:0]  addr_q, addr_d;
    logic [ADDRESS_WIDTH_P-1:0]  remaining_q, remaining_d;
    logic [DATA_WIDTH_P-1:0]     m_data_q, m_data_d;
    logic                        m_valid_q, m_valid_d;
    logic                        m_last_q, m_last_d;
    logic                        busy_q, busy_d;

    // The read address comes straight from a flop so the register file sees no input-to-address path.
    assign mem_address = addr_q;
    assign m_data      = m_data_q;
    assign m_valid     = m_valid_q;
    assign m_last      = m_last_q;
    assign busy        = busy_q;
    // A new command waits until the final beat of the previous burst has drained.
    assign cmd_ready   = (state_q == IDLE) && !m_valid_q;

    // Next-state: accept commands in IDLE, fetch one word per free output slot in READ.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d      = cmd_start_address;
                    remaining_d = cmd_length_m1;
                    state_d     = READ;
                    busy_d      = 1'b1;
                end else if (m_valid_q && m_ready) begin
                    // Only the final beat of a burst can still be pending in IDLE.
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    if (m_last_q) begin
                        busy_d = 1'b0;
                    end
                end
            end
            READ: begin
                // The output slot is free when empty or being consumed this cycle.
                if (!m_valid_q || m_ready) begin
                    m_data_d    = mem_data;
                    m_valid_d   = 1'b1;
                    m_last_d    = (remaining_q == ADDR_ZERO);
                    addr_d      = addr_q + ADDR_ONE;
                    remaining_d = remaining_q - ADDR_ONE;
                    if (remaining_q == ADDR_ZERO) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_fpga_reg_burst_reader.sv
// Purpose: randomized and directed bursts against a queue-based reference of the expected beat stream.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: m_ready driven constant, fixed pattern or random per burst.
module tb_fpga_reg_burst_reader;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_start_address;
    logic [AW-1:0] cmd_length_m1;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;

    // Register file model: one write port, asynchronous read.
    logic [DW-1:0] regfile [DEPTH];
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   hs_cnt   = 0;
    int   rdy_mode = 0;
    int   pat_i    = 0;
    logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    fpga_reg_burst_reader #(
        .DATA_WIDTH_P   (DW),
        .ADDRESS_WIDTH_P(AW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_start_address(cmd_start_address),
        .cmd_length_m1    (cmd_length_m1),
        .mem_address      (mem_address),
        .mem_data         (mem_data),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_data           (m_data),
        .m_last           (m_last),
        .busy             (busy)
    );

    assign mem_data = regfile[mem_address];

    // Register file write takes effect at the edge, so a same-edge read capture sees the old word.
    always @(posedge clk) begin
        if (we) regfile[wa] <= wd;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Consumer: m_ready policy selected per burst.
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1: begin
                    m_ready = pat[pat_i];
                    pat_i   = (pat_i + 1) % 7;
                end
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: every presented beat must match the head of the expected stream; pop on handshake.
    always @(negedge clk) begin
        if (rst_n && m_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got data 0x%0h last %0d, expected no beat", m_data, m_last);
            end else begin
                check("beat_data", 32'(m_data), 32'(exp_q[0].data));
                check("beat_last", 32'(m_last), 32'(exp_q[0].last));
                check("busy_with_valid", 32'(busy), 32'd1);
                if (m_ready) begin
                    void'(exp_q.pop_front());
                    hs_cnt++;
                end
            end
        end
    end

    // Reference: word i of the burst is the register file content at (start+i) mod depth.
    task automatic push_expected(input int start, input int lm1);
        for (int i = 0; i <= lm1; i++) begin
            exp_t e;
            e.data = regfile[(start + i) % DEPTH];
            e.last = (i == lm1);
            exp_q.push_back(e);
        end
    endtask

    task automatic issue_cmd(input int start, input int lm1);
        int w;
        w = 0;
        cmd_start_address = AW'(start);
        cmd_length_m1     = AW'(lm1);
        cmd_valid         = 1'b1;
        while (!cmd_ready && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (w >= 200) check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Runs one burst; optional same-edge write at offset col_off and stray command at ign_at.
    task automatic run_burst(input int start, input int lm1, input int mode, input bit timing_chk,
                             input int col_off, input int ign_at);
        int cyc;
        rdy_mode = mode;
        push_expected(start, lm1);
        issue_cmd(start, lm1);
        cyc = 0;
        while (busy && cyc < 500) begin
            if (col_off >= 0 && cyc == col_off) begin
                wa = AW'(start + col_off);
                wd = 8'hAA;
                we = 1'b1;
            end
            if (ign_at >= 0 && cyc == ign_at) begin
                cmd_start_address = AW'(start + 7);
                cmd_length_m1     = 4'd3;
                cmd_valid         = 1'b1;
                #0;
                check("cmd_ready_while_busy", 32'(cmd_ready), 32'd0);
            end
            @(posedge clk);
            #1;
            cyc++;
            we        = 1'b0;
            cmd_valid = 1'b0;
        end
        check("burst_terminates", 32'(busy), 32'd0);
        if (timing_chk) check("burst_cycles", 32'(cyc), 32'(lm1 + 2));
        check("cmd_ready_after_burst", 32'(cmd_ready), 32'd1);
        check("stream_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int base;
        int w;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_start_address = '0;
        cmd_length_m1 = '0;
        we = 1'b0;
        wa = '0;
        wd = '0;
        for (int i = 0; i < DEPTH; i++) regfile[i] = DW'(i + 'h10);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_mem_address", 32'(mem_address), 32'd0);

        // Basic, wrap-around, backpressure, full depth, single word
        run_burst(3, 2, 0, 1'b1, -1, -1);
        run_burst(14, 3, 0, 1'b1, -1, -1);
        pat_i = 0;
        run_burst(0, 4, 1, 1'b0, -1, -1);
        run_burst(9, 15, 2, 1'b0, -1, -1);
        run_burst(0, 15, 0, 1'b1, -1, -1);
        run_burst(7, 0, 0, 1'b1, -1, -1);

        // Same-edge write at address 5 streams the old word; stray command ignored
        run_burst(3, 4, 0, 1'b1, 2, 1);
        run_burst(5, 0, 0, 1'b1, -1, -1);

        // Reset after two of eight beats
        rdy_mode = 0;
        base = hs_cnt;
        push_expected(2, 7);
        issue_cmd(2, 7);
        w = 0;
        while (hs_cnt < base + 2 && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("reset_wait_two_beats", 32'(hs_cnt - base), 32'd2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_m_valid", 32'(m_valid), 32'd0);
        check("rst_mid_m_last", 32'(m_last), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_mid_mem_address", 32'(mem_address), 32'd0);
        run_burst(11, 5, 0, 1'b1, -1, -1);

        // Random bursts over random register file contents
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < DEPTH; i++) regfile[i] = DW'($urandom);
            run_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)),
                      int'($urandom_range(1, 2)), 1'b0, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
